// File: rtl/ss_bus_router.sv
// Savestate bus router: splits the flat word space into register bank / video RAM, returns reads after RAM_LATENCY+2 cycles.
// Writes strobe one cycle after bus_wren; no backpressure (fixed latency). Also stops the CPU at an instruction boundary for ss_halt.
`timescale 1ns/1ps
module ss_bus_router #(
   parameter logic [7:0] VRAM_START  = 8'h10,
   parameter logic [7:0] VRAM_END    = 8'h74,
   parameter int         RAM_LATENCY = 2
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [31:0] bus_in,
   input  logic [7:0]  bus_addr,
   input  logic        bus_wren,
   input  logic        bus_reset_n,
   output logic [31:0] bus_out,
   input  logic        ss_halt,
   output logic        ss_ready,
   input  logic        cpu_boundary,
   output logic        cpu_clk_en,
   output logic [7:0]  reg_addr,
   output logic        reg_wren,
   output logic [31:0] reg_wdata,
   input  logic [31:0] reg_q,
   output logic        reg_default,
   output logic [6:0]  vram_addr,
   output logic        vram_wren,
   output logic [31:0] vram_wdata,
   input  logic [31:0] vram_q,
   output logic        ss_addr_err
);

   typedef struct packed {
      logic        wren;
      logic [7:0]  addr;
      logic [31:0] dat;
   } wr_req_t;

   typedef enum logic [1:0] {
      CLS_REG  = 2'd0,
      CLS_VRAM = 2'd1,
      CLS_NONE = 2'd2
   } addr_cls_t;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_BND = 2'd1,
      ST_HALTED   = 2'd2
   } halt_st_t;

   wr_req_t     r_req;
   logic [6:0]  r_vram_addr;
   addr_cls_t   w_cls;
   logic        w_in_vram;
   logic [6:0]  w_vram_off;
   addr_cls_t   r_cls_pipe [RAM_LATENCY];
   logic [31:0] r_q_pipe   [RAM_LATENCY];
   logic [31:0] r_bus_out;
   logic        r_reg_default;
   logic        r_addr_err;
   halt_st_t    r_state;
   halt_st_t    w_state_nxt;
   logic        r_cpu_clk_en;
   logic        w_cpu_clk_en_nxt;
   logic        r_ss_ready;
   logic        w_ss_ready_nxt;

   // Class of the registered address; drives both the write strobes and the read pipeline.
   always_comb begin
      w_cls = CLS_NONE;
      if (r_req.addr < VRAM_START)
         w_cls = CLS_REG;
      else if (r_req.addr < VRAM_END)
         w_cls = CLS_VRAM;
   end

   // Out-of-window addresses park the RAM on word 0 so it never sees an index past its depth.
   assign w_in_vram  = (bus_addr >= VRAM_START) && (bus_addr < VRAM_END);
   assign w_vram_off = bus_addr[6:0] - VRAM_START[6:0];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_req       <= '0;
         r_vram_addr <= '0;
      end else begin
         r_req.wren  <= bus_wren;
         r_req.addr  <= bus_addr;
         r_req.dat   <= bus_in;
         r_vram_addr <= w_in_vram ? w_vram_off : 7'd0;
      end
   end

   assign reg_addr   = r_req.addr;
   assign reg_wdata  = r_req.dat;
   assign reg_wren   = r_req.wren && (w_cls == CLS_REG);
   assign vram_addr  = r_vram_addr;
   assign vram_wdata = r_req.dat;
   assign vram_wren  = r_req.wren && (w_cls == CLS_VRAM);

   // Register-bank data rides the same depth as the RAM so every class has equal latency.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < RAM_LATENCY; i++) begin
            r_cls_pipe[i] <= CLS_NONE;
            r_q_pipe[i]   <= '0;
         end
      end else begin
         r_cls_pipe[0] <= w_cls;
         r_q_pipe[0]   <= reg_q;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            r_cls_pipe[i] <= r_cls_pipe[i-1];
            r_q_pipe[i]   <= r_q_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset || !bus_reset_n) begin
         r_bus_out <= '0;
      end else begin
         case (r_cls_pipe[RAM_LATENCY-1])
            CLS_REG:  r_bus_out <= r_q_pipe[RAM_LATENCY-1];
            CLS_VRAM: r_bus_out <= vram_q;
            default:  r_bus_out <= '0;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_reg_default <= 1'b0;
         r_addr_err    <= 1'b0;
      end else begin
         r_reg_default <= ~bus_reset_n;
         if (!bus_reset_n)
            r_addr_err <= 1'b0;
         else if (r_req.wren && (w_cls == CLS_NONE))
            r_addr_err <= 1'b1;
      end
   end

   assign bus_out     = r_bus_out;
   assign reg_default = r_reg_default;
   assign ss_addr_err = r_addr_err;

   // Halt handshake: the CPU is only ever stopped on an instruction boundary, so there is no timeout.
   always_comb begin
      w_state_nxt      = r_state;
      w_cpu_clk_en_nxt = r_cpu_clk_en;
      w_ss_ready_nxt   = r_ss_ready;
      case (r_state)
         ST_RUN: begin
            w_cpu_clk_en_nxt = 1'b1;
            w_ss_ready_nxt   = 1'b0;
            if (ss_halt)
               w_state_nxt = ST_WAIT_BND;
         end
         ST_WAIT_BND: begin
            if (!ss_halt) begin
               w_state_nxt = ST_RUN;
            end else if (cpu_boundary) begin
               w_state_nxt      = ST_HALTED;
               w_cpu_clk_en_nxt = 1'b0;
               w_ss_ready_nxt   = 1'b1;
            end
         end
         ST_HALTED: begin
            w_cpu_clk_en_nxt = 1'b0;
            w_ss_ready_nxt   = 1'b1;
            if (!ss_halt) begin
               w_state_nxt      = ST_RUN;
               w_cpu_clk_en_nxt = 1'b1;
               w_ss_ready_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt      = ST_RUN;
            w_cpu_clk_en_nxt = 1'b1;
            w_ss_ready_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state      <= ST_RUN;
         r_cpu_clk_en <= 1'b1;
         r_ss_ready   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cpu_clk_en <= w_cpu_clk_en_nxt;
         r_ss_ready   <= w_ss_ready_nxt;
      end
   end

   assign cpu_clk_en = r_cpu_clk_en;
   assign ss_ready   = r_ss_ready;

endmodule

// File: tb/tb_ss_bus_router.sv
// Directed bench for ss_bus_router with a 16-word register bank and a 2-cycle video RAM model.
`timescale 1ns/1ps
module tb_ss_bus_router;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [31:0] bus_in;
   logic [7:0]  bus_addr;
   logic        bus_wren;
   logic        bus_reset_n;
   logic [31:0] bus_out;
   logic        ss_halt;
   logic        ss_ready;
   logic        cpu_boundary;
   logic        cpu_clk_en;
   logic [7:0]  reg_addr;
   logic        reg_wren;
   logic [31:0] reg_wdata;
   logic [31:0] reg_q;
   logic        reg_default;
   logic [6:0]  vram_addr;
   logic        vram_wren;
   logic [31:0] vram_wdata;
   logic [31:0] vram_q;
   logic        ss_addr_err;

   logic [31:0] bank [16];
   logic [31:0] vmem [128];
   logic [31:0] vq1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_sys = ~clk_sys;

   ss_bus_router dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .bus_in       (bus_in),
      .bus_addr     (bus_addr),
      .bus_wren     (bus_wren),
      .bus_reset_n  (bus_reset_n),
      .bus_out      (bus_out),
      .ss_halt      (ss_halt),
      .ss_ready     (ss_ready),
      .cpu_boundary (cpu_boundary),
      .cpu_clk_en   (cpu_clk_en),
      .reg_addr     (reg_addr),
      .reg_wren     (reg_wren),
      .reg_wdata    (reg_wdata),
      .reg_q        (reg_q),
      .reg_default  (reg_default),
      .vram_addr    (vram_addr),
      .vram_wren    (vram_wren),
      .vram_wdata   (vram_wdata),
      .vram_q       (vram_q),
      .ss_addr_err  (ss_addr_err)
   );

   // Register bank: combinational read, cleared while defaults are loaded.
   always @(posedge clk_sys) begin
      if (reg_default) begin
         for (int i = 0; i < 16; i++) bank[i] <= '0;
      end else if (reg_wren) begin
         bank[reg_addr[3:0]] <= reg_wdata;
      end
   end

   always_comb begin
      reg_q = 32'hBAD0BAD0;
      if (reg_addr < 8'd16) reg_q = bank[reg_addr[3:0]];
   end

   // Video RAM: two-cycle registered read.
   always @(posedge clk_sys) begin
      if (vram_wren) vmem[vram_addr] <= vram_wdata;
      vq1    <= vmem[vram_addr];
      vram_q <= vq1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_sys);
   endtask

   // Presents a one-cycle write and returns in the cycle where the strobe is expected.
   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus_addr = a;
      bus_in   = d;
      bus_wren = 1'b1;
      tick();
      bus_wren = 1'b0;
   endtask

   initial begin
      logic [31:0] e;
      reset        = 1'b1;
      bus_in       = '0;
      bus_addr     = '0;
      bus_wren     = 1'b0;
      bus_reset_n  = 1'b1;
      ss_halt      = 1'b0;
      cpu_boundary = 1'b0;
      tick();
      tick();

      chk("rst_bus_out", bus_out, 32'h0);
      chk("rst_ss_ready", {31'd0, ss_ready}, 32'd0);
      chk("rst_cpu_clk_en", {31'd0, cpu_clk_en}, 32'd1);
      chk("rst_strobes", {30'd0, reg_wren, vram_wren}, 32'd0);
      chk("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
      chk("rst_vram_addr", {25'd0, vram_addr}, 32'd0);
      chk("rst_default_err", {30'd0, reg_default, ss_addr_err}, 32'd0);
      reset = 1'b0;
      tick();

      // Halt handshake
      ss_halt = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("halt_wait_ready", {31'd0, ss_ready}, 32'd0);
         chk("halt_wait_clken", {31'd0, cpu_clk_en}, 32'd1);
      end
      cpu_boundary = 1'b1;
      tick();
      cpu_boundary = 1'b0;
      chk("halt_ready", {31'd0, ss_ready}, 32'd1);
      chk("halt_clken", {31'd0, cpu_clk_en}, 32'd0);
      tick();
      chk("halt_hold", {30'd0, ss_ready, cpu_clk_en}, 32'd2);
      ss_halt = 1'b0;
      tick();
      chk("release_ready", {31'd0, ss_ready}, 32'd0);
      chk("release_clken", {31'd0, cpu_clk_en}, 32'd1);

      // Abort before any boundary
      ss_halt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("abort_wait", {30'd0, ss_ready, cpu_clk_en}, 32'd1);
      end
      ss_halt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("abort_run", {30'd0, ss_ready, cpu_clk_en}, 32'd1);
      end

      // Write decode
      wr(8'h03, 32'hDEADBEEF);
      chk("wr03_reg_wren", {31'd0, reg_wren}, 32'd1);
      chk("wr03_vram_wren", {31'd0, vram_wren}, 32'd0);
      chk("wr03_reg_addr", {24'd0, reg_addr}, 32'd3);
      chk("wr03_reg_wdata", reg_wdata, 32'hDEADBEEF);
      tick();
      chk("wr03_pulse_end", {31'd0, reg_wren}, 32'd0);
      wr(8'h10, 32'h0000A5A5);
      chk("wr10_strobes", {30'd0, reg_wren, vram_wren}, 32'd1);
      chk("wr10_vram_addr", {25'd0, vram_addr}, 32'd0);
      chk("wr10_vram_wdata", vram_wdata, 32'h0000A5A5);
      wr(8'h73, 32'h5A5A0000);
      chk("wr73_strobes", {30'd0, reg_wren, vram_wren}, 32'd1);
      chk("wr73_vram_addr", {25'd0, vram_addr}, 32'd99);
      chk("pre_err_clear", {31'd0, ss_addr_err}, 32'd0);
      wr(8'h80, 32'h11111111);
      chk("wr80_strobes", {30'd0, reg_wren, vram_wren}, 32'd0);
      tick();
      chk("wr80_addr_err", {31'd0, ss_addr_err}, 32'd1);

      // Read latency
      wr(8'h15, 32'h12345678);
      bus_addr = 8'h74;
      repeat (6) tick();
      chk("rd74_zero", bus_out, 32'h0);
      bus_addr = 8'h15;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rd15_early", bus_out, 32'h0);
      end
      tick();
      chk("rd15_lat4", bus_out, 32'h12345678);
      bus_addr = 8'h74;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rd74_early", bus_out, 32'h12345678);
      end
      tick();
      chk("rd74_lat4", bus_out, 32'h0);

      // Reset while halted with a write pending
      ss_halt = 1'b1;
      tick();
      cpu_boundary = 1'b1;
      tick();
      cpu_boundary = 1'b0;
      chk("pre_rst_halted", {30'd0, ss_ready, cpu_clk_en}, 32'd2);
      bus_addr = 8'h03;
      bus_in   = 32'hAAAA5555;
      bus_wren = 1'b1;
      reset    = 1'b1;
      tick();
      bus_wren = 1'b0;
      chk("midrst_clken", {31'd0, cpu_clk_en}, 32'd1);
      chk("midrst_ready", {31'd0, ss_ready}, 32'd0);
      chk("midrst_no_strobe", {30'd0, reg_wren, vram_wren}, 32'd0);
      chk("midrst_err", {31'd0, ss_addr_err}, 32'd0);
      reset   = 1'b0;
      ss_halt = 1'b0;
      tick();
      chk("postrst_run", {30'd0, ss_ready, cpu_clk_en}, 32'd1);

      // Full sweep
      for (int a = 0; a < 116; a++) wr(8'(a), 32'(a) * 32'h01010101);
      for (int a = 0; a < 116; a++) begin
         e = 32'(a) * 32'h01010101;
         bus_addr = 8'(a);
         repeat (4) tick();
         chk($sformatf("sweep_%0d", a), bus_out, e);
         repeat (6) tick();
      end

      // Register defaults via bus_reset_n
      wr(8'h80, 32'h0);
      tick();
      chk("err_set_again", {31'd0, ss_addr_err}, 32'd1);
      bus_addr = 8'h03;
      repeat (5) tick();
      chk("rd03_before", bus_out, 32'h03030303);
      bus_reset_n = 1'b0;
      tick();
      chk("busrst_out", bus_out, 32'h0);
      chk("busrst_default", {31'd0, reg_default}, 32'd1);
      chk("busrst_err", {31'd0, ss_addr_err}, 32'd0);
      repeat (2) tick();
      chk("busrst_hold", bus_out, 32'h0);
      bus_reset_n = 1'b1;
      tick();
      chk("busrst_release", {31'd0, reg_default}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
